ref_row_fetcher: RTL and testbench

- Upstream feeder for the subpixel interpolation core.
- On `start`, reads the 15x15 integer-pixel reference window (8x8 block plus 3 left/top and 4 right/bottom filter taps) from a frame memory, one pixel per read.
- Out-of-frame coordinates are clamped to the frame edge (HEVC edge padding).
- Emits one 120-bit row per valid/ready handshake, top row first, in the format the interpolation core's `in_row` expects.

---
 rtl/ref_row_fetcher_pkg.sv | 20 ++
 rtl/ref_row_fetcher_if.sv | 26 ++
 rtl/ref_row_fetcher_coord_clamp.sv | 26 ++
 rtl/ref_row_fetcher.sv | 108 ++++++++++
 tb/tb_ref_row_fetcher.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ref_row_fetcher_pkg.sv
// Shared constants and state encoding for the reference row fetcher.
//   PIX_W/BLK_SZ/PAD_L/PAD_R : pixel width, block size and filter padding
//   ROW_PIX/ROW_W            : pixels per fetched row and packed row width
//   state_t                  : fetcher FSM states
package ref_row_fetcher_pkg;
  localparam int PIX_W     = 8;
  localparam int BLK_SZ    = 8;
  localparam int PAD_L     = 3;
  localparam int PAD_R     = 4;
  localparam int ROW_PIX   = BLK_SZ + PAD_L + PAD_R;
  localparam int ROW_W     = ROW_PIX * PIX_W;
  localparam int ROW_IDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/ref_row_fetcher_if.sv
// Frame-memory read bus plus row output handshake of the reference row fetcher.
//   master : fetcher side (drives reads and rows)
//   slave  : memory / interpolation-core side
interface ref_row_fetcher_if
  import ref_row_fetcher_pkg::*;
#(
  parameter int ADDR_W = 12
);
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [PIX_W-1:0]     mem_rd_data;
  logic [ROW_W-1:0]     row_out;
  logic                 row_valid;
  logic                 row_ready;
  logic [ROW_IDX_W-1:0] row_idx;

  modport master (
    output mem_rd_en, mem_addr, row_out, row_valid, row_idx,
    input  mem_rd_data, row_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, row_out, row_valid, row_idx,
    output mem_rd_data, row_ready
  );
endinterface

// File: rtl/ref_row_fetcher_coord_clamp.sv
// Combinational base+offset with saturation to [0, LIMIT] (frame edge padding).
//   base : unsigned block coordinate
//   off  : signed tap offset relative to base
//   eff  : clamped coordinate
module ref_row_fetcher_coord_clamp #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 12,
  parameter int LIMIT = 63
) (
  input  logic [IN_W-1:0]          base,
  input  logic signed [IN_W+1:0]   off,
  output logic [OUT_W-1:0]         eff
);
  localparam logic signed [IN_W+1:0] LIM = (IN_W+2)'(LIMIT);

  logic signed [IN_W+1:0] raw;

  // Two guard bits: one for the sign, one for the carry past the base range.
  assign raw = $signed({2'b00, base}) + off;

  always_comb begin
    eff = OUT_W'(raw);
    if (raw < 0)        eff = '0;
    else if (raw > LIM) eff = OUT_W'(LIMIT);
  end
endmodule

// File: rtl/ref_row_fetcher.sv
// Fetches the 15x15 reference window around an 8x8 block, one pixel per read,
// clamping out-of-frame coordinates, and emits one packed row per handshake.
//   clk, rst     : clock, async active-low reset
//   start        : request, accepted in IDLE only
//   blk_x, blk_y : block origin, captured on accepted start
//   busy, done   : in-progress flag, end-of-block pulse
//   bus          : frame-memory reads and row output handshake
module ref_row_fetcher
  import ref_row_fetcher_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int COORD_W = 12,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] blk_x,
  input  logic [COORD_W-1:0] blk_y,
  output logic               busy,
  output logic               done,
  ref_row_fetcher_if.master  bus
);
  localparam logic [3:0] LAST_COL = 4'(ROW_PIX);     // fc value of the capture-only cycle
  localparam logic [3:0] LAST_ROW = 4'(ROW_PIX - 1);

  state_t               state, state_n;
  logic [COORD_W-1:0]   bx, by;
  logic [3:0]           fc;       // fetch cycle within row: reads on 0..14, last capture on 15
  logic [3:0]           r;        // row counter
  logic                 rd_en;
  logic                 rd_vld_d; // read issued last cycle -> data on bus this cycle
  logic [3:0]           rd_col_d;
  logic [ROW_W-1:0]     row_q;
  logic signed [COORD_W+1:0] off_x, off_y;
  logic [ADDR_W-1:0]    x_eff, y_eff;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: if (fc == LAST_COL) state_n = S_EMIT;
      S_EMIT:  if (bus.row_ready) state_n = (r == LAST_ROW) ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign rd_en         = (state == S_FETCH) && (fc < LAST_COL);
  assign busy          = (state == S_FETCH) || (state == S_EMIT);
  assign done          = (state == S_DONE);
  assign bus.row_valid = (state == S_EMIT);
  assign bus.row_idx   = r;
  assign bus.row_out   = row_q;
  assign bus.mem_rd_en = rd_en;

  // ---------------- counters / row capture ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bx       <= '0;
      by       <= '0;
      fc       <= '0;
      r        <= '0;
      rd_vld_d <= 1'b0;
      rd_col_d <= '0;
      row_q    <= '0;
    end else begin
      rd_vld_d <= rd_en;
      rd_col_d <= fc;
      if (rd_vld_d) row_q[rd_col_d*PIX_W +: PIX_W] <= bus.mem_rd_data;
      unique case (state)
        S_IDLE: if (start) begin
          bx <= blk_x;
          by <= blk_y;
          r  <= '0;
          fc <= '0;
        end
        S_FETCH: fc <= fc + 4'd1;
        S_EMIT: if (bus.row_ready && r != LAST_ROW) begin
          r  <= r + 4'd1;
          fc <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- address generation ----------------
  assign off_x = $signed((COORD_W+2)'(fc)) - (COORD_W+2)'(PAD_L);
  assign off_y = $signed((COORD_W+2)'(r))  - (COORD_W+2)'(PAD_L);

  ref_row_fetcher_coord_clamp #(.IN_W(COORD_W), .OUT_W(ADDR_W), .LIMIT(FRAME_W-1)) u_clamp_x (
    .base(bx), .off(off_x), .eff(x_eff)
  );
  ref_row_fetcher_coord_clamp #(.IN_W(COORD_W), .OUT_W(ADDR_W), .LIMIT(FRAME_H-1)) u_clamp_y (
    .base(by), .off(off_y), .eff(y_eff)
  );

  // Clamped operands keep the product inside the frame, so ADDR_W never wraps.
  assign bus.mem_addr = rd_en ? (y_eff * ADDR_W'(FRAME_W) + x_eff) : '0;
endmodule

// File: tb/tb_ref_row_fetcher.sv
module tb_ref_row_fetcher;
  localparam int FW = 64;
  localparam int FH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] blk_x, blk_y;
  logic        busy, done;
  logic [7:0]  mem [0:4095];
  int          checks = 0;
  int          failures = 0;

  ref_row_fetcher_if #(.ADDR_W(12)) bus ();

  ref_row_fetcher #(.FRAME_W(FW), .FRAME_H(FH), .COORD_W(12), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_x(blk_x), .blk_y(blk_y),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // frame memory: one-cycle read latency
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic int ref_addr(int bx, int by, int r, int c);
    return clampi(by - 3 + r, FH - 1) * FW + clampi(bx - 3 + c, FW - 1);
  endfunction

  function automatic logic [119:0] ref_row(int bx, int by, int r);
    logic [119:0] row = '0;
    for (int k = 0; k < 15; k++) row[8*k +: 8] = mem[ref_addr(bx, by, r, k)];
    return row;
  endfunction

  task automatic fill_formula();
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++) mem[y*64 + x] = 8'((x + 2*y) & 8'hFF);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready low 10 cycles on row 2,
  // 3: stray starts during FETCH and in the DONE cycle
  task automatic run_block(input int bx, input int by, input int mode);
    int cyc = 0, r = 0, nrd = 0, stalls = 0, dones = 0, lowcnt = 0;
    logic prev_stall = 0, restart = 0;
    logic [119:0] hold_row = '0;
    logic [3:0]   hold_idx = '0;
    @(negedge clk);
    start = 1; blk_x = 12'(bx); blk_y = 12'(by); bus.row_ready = 1;
    @(negedge clk);
    start = 0;
    blk_x = 12'($urandom); blk_y = 12'($urandom);  // must not matter any more
    while (dones == 0 && cyc < 3000) begin
      // drive this cycle's inputs first; outputs do not depend on them
      case (mode)
        1: bus.row_ready = ($urandom_range(0, 3) != 0);
        2: bus.row_ready = !(r == 2 && lowcnt < 10);
        3: begin
          start = (cyc == 5);
          if (cyc == 5) begin blk_x = 12'd40; blk_y = 12'd2; end
        end
        default: bus.row_ready = 1;
      endcase
      if (restart) chk("fetch_restart", bus.mem_rd_en, 1);
      restart = 0;
      if (prev_stall) begin
        chk("hold_valid", bus.row_valid, 1);
        chk("hold_row", bus.row_out, hold_row);
        chk("hold_idx", bus.row_idx, hold_idx);
      end
      if (bus.mem_rd_en) begin
        chk("rd_addr", bus.mem_addr, ref_addr(bx, by, r, nrd));
        nrd++;
      end
      if (done) begin
        dones++;
        chk("done_cycle", cyc, 255 + stalls);
        chk("done_rows", r, 15);
        chk("done_valid", bus.row_valid, 0);
        chk("done_busy", busy, 0);
      end else begin
        chk("busy", busy, 1);
      end
      prev_stall = 0;
      if (bus.row_valid) begin
        chk("rd_in_emit", bus.mem_rd_en, 0);
        if (bus.row_ready) begin
          chk("row_data", bus.row_out, ref_row(bx, by, r));
          chk("row_idx", bus.row_idx, r);
          chk("row_nreads", nrd, 15);
          r++; nrd = 0;
          restart = (r < 15);
        end else begin
          stalls++;
          if (mode == 2) lowcnt++;
          prev_stall = 1;
          hold_row = bus.row_out;
          hold_idx = bus.row_idx;
        end
      end
      if (dones == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (dones == 0) chk("done_timeout", 0, 1);
    if (mode == 2) chk("bp_stalls", stalls, 10);
    if (mode == 3) start = 1;  // lands in the DONE cycle
    blk_x = 12'd5; blk_y = 12'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 0;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rd", bus.mem_rd_en, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd"}, bus.mem_rd_en, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_valid"}, bus.row_valid, 0);
    chk({tag, "_row"}, bus.row_out, 0);
    chk({tag, "_idx"}, bus.row_idx, 0);
  endtask

  initial begin
    int n;
    rst = 0; start = 0; blk_x = 0; blk_y = 0; bus.row_ready = 1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1;

    fill_formula();
    run_block(16, 16, 0);
    run_block(0, 0, 0);
    run_block(56, 56, 0);
    run_block(16, 16, 2);
    run_block(10, 20, 3);

    fill_random();
    for (int i = 0; i < 4; i++)
      run_block($urandom_range(0, 70), $urandom_range(0, 70), 1);
    run_block(4095, 3, 1);

    // asynchronous reset in the middle of row 7's fetch
    @(negedge clk);
    start = 1; blk_x = 12'd30; blk_y = 12'd30;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(bus.row_idx == 4'd7 && bus.mem_rd_en) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_row7", n < 400, 1);
    #2 rst = 0;
    #1 chk_zero("midrst");
    @(negedge clk);
    chk("midrst_nodone", done, 0);
    rst = 1;
    run_block(8, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
